// File: rtl/gb_breakpoints_pkg.sv
// Shared types and widths for the GB80 debug breakpoint register.
package gb_breakpoints_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 16;

    // Which address byte the next strobe writes.
    typedef enum logic {
        PTR_LOW  = 1'b0,
        PTR_HIGH = 1'b1
    } bp_ptr_e;

endpackage : gb_breakpoints_pkg

// File: rtl/gb_rise_detect.sv
// 1-bit rising-edge detector for debug strobes and buttons.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : level input, sampled each rising clock edge
//   rise_c     : combinational, high while din=1 and its previous-cycle value was 0
// The history register resets to 0, so an input already high at the first
// edge after reset release counts as one rise.
module gb_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic din_q;

    // Previous-cycle copy of the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise_c = din & ~din_q;

endmodule : gb_rise_detect

// File: rtl/gb_breakpoints.sv
// Debug breakpoint address register for the GB80 CPU.
// Builds a 16-bit breakpoint address one byte per strobe rise (low byte
// first, then high byte, then wrapping) and exposes a byte-wide readback.
// Ports:
//   clock            : system clock, rising edge
//   reset            : asynchronous active-low reset
//   bp_addr_part_in  : byte to write on the next strobe rise
//   bp_hi_lo_sel_in  : write strobe; each 0->1 transition writes one byte
//   bp_hi_lo_disp_in : readback select, 0 = low byte, 1 = high byte
//   bp_addr          : registered breakpoint address to the CPU
//   bp_addr_disp     : combinational view of the selected byte of bp_addr
module gb_breakpoints
    import gb_breakpoints_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEFAULT_ADDR = 16'hFFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BYTE_W-1:0] bp_addr_part_in,
    input  logic              bp_hi_lo_sel_in,
    input  logic              bp_hi_lo_disp_in,
    output logic [ADDR_W-1:0] bp_addr,
    output logic [BYTE_W-1:0] bp_addr_disp
);

    logic    wr_c;
    bp_ptr_e ptr;

    gb_rise_detect u_sel_rise (
        .clk    (clock),
        .rst_n  (reset),
        .din    (bp_hi_lo_sel_in),
        .rise_c (wr_c)
    );

    // Byte registers and write pointer; the unwritten byte keeps its value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bp_addr <= DEFAULT_ADDR;
            ptr     <= PTR_LOW;
        end else if (wr_c) begin
            if (ptr == PTR_LOW) begin
                bp_addr[BYTE_W-1:0] <= bp_addr_part_in;
                ptr                 <= PTR_HIGH;
            end else begin
                bp_addr[ADDR_W-1:BYTE_W] <= bp_addr_part_in;
                ptr                      <= PTR_LOW;
            end
        end
    end

    // Readback mux, no added register.
    always_comb begin
        bp_addr_disp = bp_addr[BYTE_W-1:0];
        if (bp_hi_lo_disp_in) begin
            bp_addr_disp = bp_addr[ADDR_W-1:BYTE_W];
        end
    end

endmodule : gb_breakpoints

// File: tb/tb_gb_breakpoints.sv
// Directed self-checking bench for gb_breakpoints.
module tb_gb_breakpoints;

    logic        clock;
    logic        reset;
    logic [7:0]  part;
    logic        sel;
    logic        disp;
    logic [15:0] addr;
    logic [7:0]  addr_disp;
    logic [15:0] addr2;
    logic [7:0]  addr_disp2;

    int checks;
    int errors;

    gb_breakpoints dut (
        .clock            (clock),
        .reset            (reset),
        .bp_addr_part_in  (part),
        .bp_hi_lo_sel_in  (sel),
        .bp_hi_lo_disp_in (disp),
        .bp_addr          (addr),
        .bp_addr_disp     (addr_disp)
    );

    gb_breakpoints #(.DEFAULT_ADDR(16'h0150)) dut_ovr (
        .clock            (clock),
        .reset            (reset),
        .bp_addr_part_in  (part),
        .bp_hi_lo_sel_in  (sel),
        .bp_hi_lo_disp_in (disp),
        .bp_addr          (addr2),
        .bp_addr_disp     (addr_disp2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One-cycle strobe pulse with the given byte, then strobe low for a cycle.
    task automatic strobe(input logic [7:0] b);
        part = b;
        sel  = 1'b1;
        tick();
        sel  = 1'b0;
        tick();
    endtask

    // Reset between edges with strobe low, release between edges.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        sel   = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        part   = 8'h00;
        sel    = 1'b0;
        disp   = 1'b0;

        // Reset held with toggling inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            part = 8'($urandom);
            sel  = 1'($urandom);
            disp = 1'($urandom);
        end
        check("rst_hold_addr", addr, 16'hFFFF);
        check("rst_hold_ovr", addr2, 16'h0150);
        @(negedge clock);
        sel   = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_addr", addr, 16'hFFFF);
        disp = 1'b0; #1;
        check("rst_disp_lo", 16'(addr_disp), 16'h00FF);
        check("ovr_disp_lo", 16'(addr_disp2), 16'h0050);
        disp = 1'b1; #1;
        check("rst_disp_hi", 16'(addr_disp), 16'h00FF);
        check("ovr_addr", addr2, 16'h0150);
        check("ovr_disp_hi", 16'(addr_disp2), 16'h0001);

        // Two-byte write.
        strobe(8'h03);
        disp = 1'b1; #1;
        check("wr_lo_addr", addr, 16'hFF03);
        check("wr_lo_disp_hi", 16'(addr_disp), 16'h00FF);
        strobe(8'h00);
        check("wr_hi_addr", addr, 16'h0003);
        disp = 1'b0; #1;
        check("wr_hi_disp_lo", 16'(addr_disp), 16'h0003);
        disp = 1'b1; #1;
        check("wr_hi_disp_hi", 16'(addr_disp), 16'h0000);

        // Held strobe: one write only; data changes while held are ignored.
        do_reset();
        part = 8'hA5;
        sel  = 1'b1;
        tick();
        check("held_first", addr, 16'hFFA5);
        part = 8'h5A;
        repeat (5) tick();
        check("held_during", addr, 16'hFFA5);
        sel = 1'b0;
        tick();
        part = 8'h99;
        repeat (2) tick();
        check("held_after", addr, 16'hFFA5);
        strobe(8'hBB);
        check("held_ptr_high", addr, 16'hBBA5);

        // Wrap-around.
        do_reset();
        strobe(8'h12);
        check("wrap_1", addr, 16'hFF12);
        strobe(8'h34);
        check("wrap_2", addr, 16'h3412);
        strobe(8'h56);
        check("wrap_3", addr, 16'h3456);

        // Asynchronous reset mid-sequence.
        do_reset();
        strobe(8'h77);
        check("mid_lo", addr, 16'hFF77);
        #2;
        reset = 1'b0;
        #1;
        check("mid_async", addr, 16'hFFFF);
        disp = 1'b0; #1;
        check("mid_disp", 16'(addr_disp), 16'h00FF);
        @(negedge clock);
        reset = 1'b1;
        tick();
        strobe(8'h10);
        check("mid_restart", addr, 16'hFF10);
        strobe(8'h20);
        check("mid_second", addr, 16'h2010);

        // Strobe already high at the first edge after release.
        @(negedge clock);
        reset = 1'b0;
        part  = 8'hC4;
        sel   = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("rel_high_sel", addr, 16'hFFC4);
        sel = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gb_breakpoints
